// File: rtl/ysyx_23060203_alu_arb_if.sv
// Bundle between the ALU arbiter and its neighbours: two requesters,
// two result consumers, the shared-ALU operand/result pair and stall_cnt.
interface ysyx_23060203_alu_arb_if #(
  parameter int TAG_W = 4
);
  logic             r0_valid;
  logic             r0_ready;
  logic [31:0]      r0_a;
  logic [31:0]      r0_b;
  logic [2:0]       r0_funct;
  logic             r0_funcs;
  logic [TAG_W-1:0] r0_tag;

  logic             r1_valid;
  logic             r1_ready;
  logic [31:0]      r1_a;
  logic [31:0]      r1_b;
  logic [2:0]       r1_funct;
  logic             r1_funcs;
  logic [TAG_W-1:0] r1_tag;

  logic             d0_valid;
  logic             d0_ready;
  logic [31:0]      d0_val;
  logic [TAG_W-1:0] d0_tag;

  logic             d1_valid;
  logic             d1_ready;
  logic [31:0]      d1_val;
  logic [TAG_W-1:0] d1_tag;

  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [2:0]       alu_funct;
  logic             alu_funcs;
  logic [31:0]      alu_val;

  logic [15:0]      stall_cnt;

  modport master (
    output r0_valid, r0_a, r0_b, r0_funct,
    output r0_funcs, r0_tag,
    input  r0_ready,
    output r1_valid, r1_a, r1_b, r1_funct,
    output r1_funcs, r1_tag,
    input  r1_ready,
    input  d0_valid, d0_val, d0_tag,
    output d0_ready,
    input  d1_valid, d1_val, d1_tag,
    output d1_ready,
    input  alu_a, alu_b, alu_funct, alu_funcs,
    output alu_val,
    input  stall_cnt
  );

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_funct,
    input  r0_funcs, r0_tag,
    output r0_ready,
    input  r1_valid, r1_a, r1_b, r1_funct,
    input  r1_funcs, r1_tag,
    output r1_ready,
    output d0_valid, d0_val, d0_tag,
    input  d0_ready,
    output d1_valid, d1_val, d1_tag,
    input  d1_ready,
    output alu_a, alu_b, alu_funct, alu_funcs,
    input  alu_val,
    output stall_cnt
  );
endinterface

// File: rtl/ysyx_23060203_alu_arb.sv
// Round-robin sharing of one combinational ALU between EXU (port 0)
// and LSU (port 1); per-port registered result with valid/ready.
// Ports: clock, reset (async, active-high), bus (slave side).
module ysyx_23060203_alu_arb #(
  parameter int TAG_W = 4
) (
  input logic                    clock,
  input logic                    reset,
  ysyx_23060203_alu_arb_if.slave bus
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  funct;
    logic        funcs;
  } op_t;

  op_t op0;
  op_t op1;
  op_t sel;

  logic             d0_valid_q;
  logic             d1_valid_q;
  logic [31:0]      d0_val_q;
  logic [31:0]      d1_val_q;
  logic [TAG_W-1:0] d0_tag_q;
  logic [TAG_W-1:0] d1_tag_q;
  logic             prio_q;
  logic             prio_d;
  logic [15:0]      stall_q;
  logic [15:0]      stall_d;

  logic free0;
  logic free1;
  logic elig0;
  logic elig1;
  logic rdy0;
  logic rdy1;
  logic fire0;
  logic fire1;
  logic use_funcs;

  assign op0 = {bus.r0_a, bus.r0_b,
                bus.r0_funct, bus.r0_funcs};
  assign op1 = {bus.r1_a, bus.r1_b,
                bus.r1_funct, bus.r1_funcs};

  // A slot is free when empty or draining now,
  // so a port can refill the same cycle it drains.
  always_comb begin
    free0 = !d0_valid_q | bus.d0_ready;
    free1 = !d1_valid_q | bus.d1_ready;
    elig0 = bus.r0_valid & free0;
    elig1 = bus.r1_valid & free1;
    rdy0  = free0 & (!prio_q | !elig1);
    rdy1  = free1 & (prio_q | !elig0);
    fire0 = bus.r0_valid & rdy0;
    fire1 = bus.r1_valid & rdy1;
  end

  always_comb begin
    sel = '0;
    unique case (1'b1)
      fire0:   sel = op0;
      fire1:   sel = op1;
      default: sel = '0;
    endcase
  end

  // funcs only has meaning for ADD (sub) and SHR (arith).
  assign use_funcs = (sel.funct == 3'b000)
                   | (sel.funct == 3'b101);

  assign bus.alu_a     = sel.a;
  assign bus.alu_b     = sel.b;
  assign bus.alu_funct = sel.funct;
  assign bus.alu_funcs = sel.funcs & use_funcs;

  // Winner hands priority to the other port.
  always_comb begin
    prio_d = prio_q;
    unique case (1'b1)
      fire0:   prio_d = 1'b1;
      fire1:   prio_d = 1'b0;
      default: prio_d = prio_q;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (elig0 & elig1 & ~&stall_q)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      prio_q  <= prio_d;
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d0_valid_q <= 1'b0;
      d0_val_q   <= '0;
      d0_tag_q   <= '0;
    end else if (fire0) begin
      d0_valid_q <= 1'b1;
      d0_val_q   <= bus.alu_val;
      d0_tag_q   <= bus.r0_tag;
    end else if (bus.d0_ready) begin
      d0_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d1_valid_q <= 1'b0;
      d1_val_q   <= '0;
      d1_tag_q   <= '0;
    end else if (fire1) begin
      d1_valid_q <= 1'b1;
      d1_val_q   <= bus.alu_val;
      d1_tag_q   <= bus.r1_tag;
    end else if (bus.d1_ready) begin
      d1_valid_q <= 1'b0;
    end
  end

  assign bus.r0_ready  = rdy0;
  assign bus.r1_ready  = rdy1;
  assign bus.d0_valid  = d0_valid_q;
  assign bus.d0_val    = d0_val_q;
  assign bus.d0_tag    = d0_tag_q;
  assign bus.d1_valid  = d1_valid_q;
  assign bus.d1_val    = d1_val_q;
  assign bus.d1_tag    = d1_tag_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_ysyx_23060203_alu_arb.sv
// Bench for ysyx_23060203_alu_arb: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_ysyx_23060203_alu_arb;
  localparam int TAG_W = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ysyx_23060203_alu_arb_if #(.TAG_W(TAG_W)) bus ();

  ysyx_23060203_alu_arb #(.TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic             rv [2];
  logic             rs [2];
  logic             dr [2];
  logic [31:0]      ra [2];
  logic [31:0]      rb [2];
  logic [2:0]       rf [2];
  logic [TAG_W-1:0] rt [2];

  assign bus.r0_valid = rv[0];
  assign bus.r0_a     = ra[0];
  assign bus.r0_b     = rb[0];
  assign bus.r0_funct = rf[0];
  assign bus.r0_funcs = rs[0];
  assign bus.r0_tag   = rt[0];
  assign bus.r1_valid = rv[1];
  assign bus.r1_a     = ra[1];
  assign bus.r1_b     = rb[1];
  assign bus.r1_funct = rf[1];
  assign bus.r1_funcs = rs[1];
  assign bus.r1_tag   = rt[1];
  assign bus.d0_ready = dr[0];
  assign bus.d1_ready = dr[1];

  // Behavioural ALU; a set funcs on an op that ignores it yields junk.
  function automatic logic [31:0] alu_fn(
    input logic [31:0] a, input logic [31:0] b,
    input logic [2:0] f, input logic s);
    logic [31:0] r;
    if (s && f != 3'd0 && f != 3'd5) return 32'hDEADBEEF;
    case (f)
      3'd0: r = s ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = {31'b0, $signed(a) < $signed(b)};
      3'd3: r = {31'b0, a < b};
      3'd4: r = a ^ b;
      3'd5: r = s ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  assign bus.alu_val = alu_fn(bus.alu_a, bus.alu_b,
                              bus.alu_funct, bus.alu_funcs);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  logic             mdv   [2];
  logic [31:0]      mval  [2];
  logic [TAG_W-1:0] mtag  [2];
  logic             fired [2];
  int mprio;
  int mstall;
  int win;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mdv[i] = 1'b0; mval[i] = '0; mtag[i] = '0;
      fired[i] = 1'b0;
    end
    mprio = 0; mstall = 0;
  endtask

  function automatic logic eff_funcs(input int i);
    return rs[i] && (rf[i] == 3'd0 || rf[i] == 3'd5);
  endfunction

  // One clock: check combinational outputs, advance the model
  // through the edge, then check the registered outputs.
  task automatic cycle();
    logic free [2];
    logic want [2];
    logic [31:0] ea, eb;
    logic [2:0]  ef;
    logic        es;
    #1;
    for (int i = 0; i < 2; i++) begin
      free[i] = !mdv[i] || dr[i];
      want[i] = rv[i] && free[i];
    end
    if (want[0] && want[1]) win = mprio;
    else if (want[0])       win = 0;
    else if (want[1])       win = 1;
    else                    win = -1;
    chk("r0_ready", 32'(bus.r0_ready),
        32'(free[0] && !(want[1] && mprio != 0)));
    chk("r1_ready", 32'(bus.r1_ready),
        32'(free[1] && !(want[0] && mprio != 1)));
    ea = '0; eb = '0; ef = '0; es = 1'b0;
    if (win >= 0) begin
      ea = ra[win]; eb = rb[win]; ef = rf[win];
      es = eff_funcs(win);
    end
    chk("alu_a", bus.alu_a, ea);
    chk("alu_b", bus.alu_b, eb);
    chk("alu_funct", 32'(bus.alu_funct), 32'(ef));
    chk("alu_funcs", 32'(bus.alu_funcs), 32'(es));
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      fired[i] = (win == i);
      if (fired[i]) begin
        mdv[i]  = 1'b1;
        mval[i] = alu_fn(ra[i], rb[i], rf[i], eff_funcs(i));
        mtag[i] = rt[i];
      end else if (dr[i]) begin
        mdv[i] = 1'b0;
      end
    end
    if (win >= 0) mprio = 1 - win;
    if (want[0] && want[1] && mstall < 65535) mstall++;
    chk("d0_valid", 32'(bus.d0_valid), 32'(mdv[0]));
    chk("d1_valid", 32'(bus.d1_valid), 32'(mdv[1]));
    chk("d0_val", bus.d0_val, mval[0]);
    chk("d1_val", bus.d1_val, mval[1]);
    chk("d0_tag", 32'(bus.d0_tag), 32'(mtag[0]));
    chk("d1_tag", 32'(bus.d1_tag), 32'(mtag[1]));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(mstall));
  endtask

  task automatic setreq(input int i, input logic v,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, input logic s,
                        input logic [TAG_W-1:0] t);
    rv[i] = v; ra[i] = a; rb[i] = b;
    rf[i] = f; rs[i] = s; rt[i] = t;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      setreq(i, 1'b0, '0, '0, '0, 1'b0, '0);
      dr[i] = 1'b1;
    end
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_d0_valid", 32'(bus.d0_valid), 32'd0);
    chk("rst_d1_valid", 32'(bus.d1_valid), 32'd0);
    chk("rst_d0_val", bus.d0_val, 32'd0);
    chk("rst_d1_tag", 32'(bus.d1_tag), 32'd0);
    chk("rst_stall", 32'(bus.stall_cnt), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_funct", 32'(bus.alu_funct), 32'd0);
    reset = 1'b0;

    setreq(0, 1'b1, 32'd5, 32'd7, 3'd0, 1'b0, 4'd3);
    #1 chk("idle_r0_ready", 32'(bus.r0_ready), 32'd1);
    cycle();
    chk("add_val", bus.d0_val, 32'd12);
    chk("add_tag", 32'(bus.d0_tag), 32'd3);
    chk("add_valid", 32'(bus.d0_valid), 32'd1);
    setreq(0, 1'b1, 32'd10, 32'd3, 3'd0, 1'b1, 4'd5);
    cycle();
    chk("sub_val", bus.d0_val, 32'd7);
    chk("sub_valid", 32'(bus.d0_valid), 32'd1);
    rv[0] = 1'b0;
    cycle();

    pulse_reset();
    setreq(0, 1'b1, 32'd1, 32'd1, 3'd0, 1'b0, 4'd1);
    setreq(1, 1'b1, 32'd1, 32'd2, 3'd3, 1'b0, 4'd2);
    #1;
    chk("cont_r0_ready", 32'(bus.r0_ready), 32'd1);
    chk("cont_r1_ready", 32'(bus.r1_ready), 32'd0);
    cycle();
    rv[0] = 1'b0;
    cycle();
    chk("cont_d1_val", bus.d1_val, 32'd1);
    chk("cont_stall", 32'(bus.stall_cnt), 32'd1);
    rv[1] = 1'b0;
    setreq(0, 1'b1, 32'd2, 32'd2, 3'd6, 1'b0, 4'd4);
    setreq(1, 1'b1, 32'd3, 32'd9, 3'd2, 1'b0, 4'd6);
    #1 chk("prio0_r1_ready", 32'(bus.r1_ready), 32'd0);
    cycle();
    rv[0] = 1'b0;
    cycle();
    rv[1] = 1'b0;
    cycle();

    dr[0] = 1'b0;
    setreq(0, 1'b1, 32'd100, 32'd23, 3'd0, 1'b0, 4'd7);
    cycle();
    setreq(0, 1'b1, 32'd9, 32'd4, 3'd4, 1'b0, 4'd8);
    for (int k = 0; k < 4; k++) begin
      setreq(1, 1'b1, 32'(k), 32'(k + 1), 3'd0, 1'b0, 4'(k));
      #1;
      chk("bp_r0_ready", 32'(bus.r0_ready), 32'd0);
      chk("bp_r1_ready", 32'(bus.r1_ready), 32'd1);
      cycle();
      chk("bp_hold", bus.d0_val, 32'd123);
    end
    dr[0] = 1'b1;
    setreq(1, 1'b1, 32'd6, 32'd6, 3'd7, 1'b0, 4'd9);
    #1 chk("bp_release", 32'(bus.r0_ready), 32'd1);
    cycle();
    chk("bp_new_valid", 32'(bus.d0_valid), 32'd1);
    chk("bp_new_val", bus.d0_val, 32'd13);
    rv[0] = 1'b0;
    cycle();
    rv[1] = 1'b0;
    cycle();

    setreq(1, 1'b1, 32'hF0, 32'h0F, 3'd6, 1'b1, 4'd9);
    #1 chk("or_funcs", 32'(bus.alu_funcs), 32'd0);
    cycle();
    chk("or_val", bus.d1_val, 32'hFF);
    setreq(1, 1'b1, 32'h80000000, 32'd4, 3'd5, 1'b1, 4'd10);
    #1 chk("sra_funcs", 32'(bus.alu_funcs), 32'd1);
    cycle();
    chk("sra_val", bus.d1_val, 32'hF8000000);
    setreq(1, 1'b1, 32'h80000000, 32'd4, 3'd5, 1'b0, 4'd11);
    cycle();
    chk("srl_val", bus.d1_val, 32'h08000000);
    rv[1] = 1'b0;
    cycle();

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] || fired[i])
          setreq(i, $urandom_range(0, 3) != 0, $urandom,
                 $urandom_range(0, 1) ? $urandom
                                      : 32'($urandom_range(0, 40)),
                 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 TAG_W'($urandom));
        dr[i] = $urandom_range(0, 3) != 0;
      end
      cycle();
    end

    setreq(0, 1'b1, 32'd1, 32'd2, 3'd0, 1'b0, 4'd1);
    setreq(1, 1'b1, 32'd3, 32'd4, 3'd4, 1'b0, 4'd2);
    dr[0] = 1'b1;
    dr[1] = 1'b1;
    repeat (70000) cycle();
    chk("sat_stall", 32'(bus.stall_cnt), 32'hFFFF);
    dr[1] = 1'b0;
    repeat (2) cycle();
    chk("pre_rst_d1", 32'(bus.d1_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_d1_valid", 32'(bus.d1_valid), 32'd0);
    chk("async_stall", 32'(bus.stall_cnt), 32'd0);
    model_reset();
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    dr[1] = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
